quad_encoder_gen: RTL and testbench
===================================

Name: quad_encoder_gen

Overview:
- Quadrature transmitter: turns step commands into signal_a/signal_b waveforms, the same protocol the rotary-encoder reader decodes.
- Emulates a physical rotary encoder for hardware-in-the-loop testing of the sequencer UI, and drives external quadrature inputs.
- Exports the 3-bit position a matching decoder ends at, for self-checking.

Parameters:
- PHASE_CYCLES, 1000: clk cycles each quadrature phase value is held; must be >= 1.
- STEP_W, 4: width of cmd_steps.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  step command present.
- cmd_ready  output  1  generator idle and accepting a command.
- cmd_dir  input  1  0 = increment (CW), 1 = decrement (CCW).
- cmd_steps  input  STEP_W  number of detents to emit; 0 is legal.
- signal_a  output  1  quadrature channel A.
- signal_b  output  1  quadrature channel B.
- busy  output  1  command in progress; equals !cmd_ready.
- done  output  1  one-cycle pulse when a command completes.
- position  output  3  decoder-equivalent position; wraps mod 8.

Behaviour:
- Reset, sampled at posedge clk: signal_a=0, signal_b=0, position=0, done=0, cmd_ready=1, busy=0. Timer and remaining count cleared, FSM to IDLE.
- Reset mid-command aborts at once. Outputs return to 00 on that edge even if that leaves a partial quadrature cycle.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_dir and cmd_steps are captured at that edge. cmd_valid while busy is ignored, and no command is queued.
- FSM states:
  - IDLE: cmd_ready=1.
  - STEP: cmd_ready=0. Tracks phase index 0..3 and a timer counting 0..PHASE_CYCLES-1.
  - FINISH: one cycle; done=1, cmd_ready=0. Then IDLE.
- One detent is 4 phases, each held exactly PHASE_CYCLES cycles. Values (A,B) per phase index 0..3:
  - CW: 10, 11, 01, 00.
  - CCW: 01, 11, 10, 00.
- Decoder contract: signal_a rises exactly once per detent.
  - CW: the rise is at phase 0 with B=0, so the decoder increments.
  - CCW: the rise is at phase 1 with B=1, so the decoder decrements.
- Timing: the accept edge with cmd_steps>0 sets signal_a/signal_b to the phase-0 value (1-cycle latency from cmd_valid sampled).
  - Phase advances each time the timer reaches PHASE_CYCLES-1.
  - After phase 3 completes, the remaining count decrements. If nonzero, the next edge starts phase 0 of the next detent with no gap. If zero, go to FINISH.
- Duration: a command of N>0 steps keeps busy high for 4*N*PHASE_CYCLES+1 cycles (STEP cycles plus FINISH), then cmd_ready returns.
- cmd_steps=0: accept goes straight to FINISH. done pulses the next cycle; outputs stay 00 and position is unchanged.
- position updates on the same edge signal_a goes 0->1: +1 for CW, -1 for CCW, mod 8 (7->0, 0->7).
- Outputs are registered, with no combinational path from inputs to signal_a/signal_b.
- Between commands and after completion, outputs rest at 00.
- Remaining counter is STEP_W bits; the maximum command is 2^STEP_W-1 detents.

Optional Feature:
- Macro: QUAD_ENCODER_GEN_ABORT_EN.
- When defined: adds input port abort (1 bit).
  - abort sampled high while busy latches an abort request.
  - The current detent completes through phase 3, so outputs end at 00 and position stays consistent with any decoder.
  - Then FINISH pulses done and the FSM returns to IDLE; remaining steps are discarded.
  - abort in IDLE or FINISH has no effect, and the request clears on return to IDLE.
- When undefined: no abort port; every accepted command runs to completion.

Test Plan (PHASE_CYCLES=2, STEP_W=4):
- Reset with cmd_valid=1 -> during and one cycle after reset: A/B=00, position=0, cmd_ready=1, done=0, nothing accepted while rst high.
- CW, steps=1 from position 0 -> A/B per cycle from accept edge: 10,10,11,11,01,01,00,00. Then done=1 for one cycle, cmd_ready=1 the next cycle. position goes 1 on the first cycle.
- CCW, steps=2 from position 0 -> A/B 01,01,11,11,10,10,00,00 repeated twice. position 7 at first A rise, 6 at second. done after 16 STEP cycles.
- CW, steps=9 from 0 -> position sequence 1..7,0,1 (wrap checked); done at cycle 73. A reference decoder model counts 9 increments.
- steps=0 -> done on next cycle, A/B never leave 00, position unchanged. Back-to-back command with cmd_valid held high is accepted the cycle cmd_ready rises.
- rst asserted mid-phase 1 of a CW 3-step command -> next edge A/B=00, position=0, cmd_ready=1. With ABORT_EN, abort in phase 1 of detent 2 of 5 -> detent 2 completes, done pulses, position=+2.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature transmitter that turns step commands into
// signal_a/signal_b waveforms and tracks the position a matching decoder
// would reach. Optional abort input is enabled by QUAD_ENCODER_GEN_ABORT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | outputs at 00, cmd_ready high, waiting for a command
// S_STEP   | emitting detents: phase index 0..3, timer 0..PHASE_CYCLES-1
// S_FINISH | one cycle, done pulses, then back to S_IDLE
module quad_encoder_gen #(
   parameter int PHASE_CYCLES = 1000,
   parameter int STEP_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
`ifdef QUAD_ENCODER_GEN_ABORT_EN
   input  logic              abort,
`endif
   output logic              signal_a,
   output logic              signal_b,
   output logic              busy,
   output logic              done,
   output logic [2:0]        position
);

   localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_FINISH} state_t;

   state_t            state_q, state_d;
   logic [1:0]        phase_q, phase_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [STEP_W-1:0] remain_q, remain_d;
   logic              dir_q, dir_d;
   logic              a_q, a_d;
   logic              b_q, b_d;
   logic [2:0]        pos_q, pos_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              abort_req_q, abort_req_d;
   logic              abort_hit;
   logic [1:0]        ab_next;
   logic              dir_now;

   // (A,B) for a given direction and phase index; A leads B for CW
   function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] ph);
      logic [1:0] ab;
      ab = 2'b00;
      case (ph)
         2'd0: ab = dir ? 2'b01 : 2'b10;
         2'd1: ab = 2'b11;
         2'd2: ab = dir ? 2'b10 : 2'b01;
         default: ab = 2'b00;
      endcase
      return ab;
   endfunction

`ifdef QUAD_ENCODER_GEN_ABORT_EN
   assign abort_hit = abort_req_q | abort;
`else
   assign abort_hit = 1'b0;
`endif

   // next-state, phase/timer sequencing and decoder-equivalent position
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      timer_d     = timer_q;
      remain_d    = remain_q;
      dir_d       = dir_q;
      abort_req_d = abort_req_q;
      ab_next     = {a_q, b_q};
      dir_now     = dir_q;
      case (state_q)
         S_IDLE: begin
            abort_req_d = 1'b0;
            dir_now     = cmd_dir;
            if (cmd_valid && ready_q) begin
               dir_d    = cmd_dir;
               remain_d = cmd_steps;
               timer_d  = '0;
               phase_d  = 2'd0;
               if (cmd_steps == '0) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_STEP;
                  ab_next = phase_ab(cmd_dir, 2'd0);
               end
            end
         end
         S_STEP: begin
            if (abort_hit) abort_req_d = 1'b1;
            if (timer_q == T_LAST) begin
               timer_d = '0;
               if (phase_q == 2'd3) begin
                  remain_d = remain_q - STEP_W'(1);
                  // detent boundary: outputs are already at 00 here
                  if ((remain_q == STEP_W'(1)) || abort_hit) begin
                     state_d = S_FINISH;
                  end else begin
                     phase_d = 2'd0;
                     ab_next = phase_ab(dir_q, 2'd0);
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
                  ab_next = phase_ab(dir_q, phase_q + 2'd1);
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      a_d = ab_next[1];
      b_d = ab_next[0];
      pos_d = pos_q;
      // count exactly where a decoder would: on the A rising edge
      if (!a_q && ab_next[1]) pos_d = pos_q + (dir_now ? 3'd7 : 3'd1);
      done_d  = (state_d == S_FINISH);
      ready_d = (state_d == S_IDLE);
   end

   // state and registered outputs, synchronous reset aborts immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= 2'd0;
         timer_q     <= '0;
         remain_q    <= '0;
         dir_q       <= 1'b0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         pos_q       <= 3'd0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
         abort_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         timer_q     <= timer_d;
         remain_q    <= remain_d;
         dir_q       <= dir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pos_q       <= pos_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         abort_req_q <= abort_req_d;
      end
   end

   assign signal_a  = a_q;
   assign signal_b  = b_q;
   assign position  = pos_q;
   assign done      = done_q;
   assign cmd_ready = ready_q;
   assign busy      = ~ready_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Testbench for quad_encoder_gen with PHASE_CYCLES=2, STEP_W=4.
// Expected per-cycle outputs are queued at stimulus time; a negedge monitor
// pops and compares them, and a reference decoder cross-checks position.
module tb_quad_encoder_gen;

   localparam int PC = 2;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_dir;
   logic [SW-1:0] cmd_steps;
   logic          signal_a, signal_b, busy, done;
   logic [2:0]    position;
`ifdef QUAD_ENCODER_GEN_ABORT_EN
   logic          abort = 1'b0;
`endif

   quad_encoder_gen #(.PHASE_CYCLES(PC), .STEP_W(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
`ifdef QUAD_ENCODER_GEN_ABORT_EN
      .abort     (abort),
`endif
      .signal_a  (signal_a),
      .signal_b  (signal_b),
      .busy      (busy),
      .done      (done),
      .position  (position)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] ab;
      logic [2:0] pos;
      logic       done;
      logic       ready;
   } exp_t;

   exp_t       sbq[$];
   logic [1:0] CW_T  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] CCW_T [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic [2:0] exp_pos = 3'd0;
   logic [2:0] dec_pos = 3'd0;
   logic       prev_a  = 1'b0;
   int         n_cmp   = 0;
   int         n_err   = 0;

   function automatic exp_t mk(input logic [1:0] ab, input logic [2:0] pos,
                               input logic dn, input logic rdy);
      exp_t e;
      e.ab = ab; e.pos = pos; e.done = dn; e.ready = rdy;
      return e;
   endfunction

   // queue expectations for a command; lim >= 0 keeps only the first lim STEP cycles
   task automatic push_cmd(input logic dir, input int n, input int lim);
      int cnt;
      logic [1:0] ab;
      cnt = 0;
      for (int d = 0; d < n; d++)
         for (int ph = 0; ph < 4; ph++)
            for (int t = 0; t < PC; t++) begin
               ab = dir ? CCW_T[ph] : CW_T[ph];
               if (t == 0 && ph == (dir ? 1 : 0))
                  exp_pos = dir ? exp_pos - 3'd1 : exp_pos + 3'd1;
               if (lim < 0 || cnt < lim) sbq.push_back(mk(ab, exp_pos, 1'b0, 1'b0));
               cnt++;
            end
      if (lim < 0) begin
         sbq.push_back(mk(2'b00, exp_pos, 1'b1, 1'b0));
         sbq.push_back(mk(2'b00, exp_pos, 1'b0, 1'b1));
      end
   endtask

   // called at posedge+1 in an idle cycle; returns at posedge+1 of the next idle cycle
   task automatic run_cmd(input logic dir, input int n, input logic hold);
      int cycles;
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_steps = SW'(n);
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      push_cmd(dir, n, -1);
      cycles = (n == 0) ? 1 : 4 * n * PC + 1;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_pos = 3'd0;
      sbq.push_back(mk(2'b00, 3'd0, 1'b0, 1'b1));
   endtask

   // monitor: reference decoder plus scoreboard pop on every falling edge
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         dec_pos = 3'd0;
         prev_a  = 1'b0;
      end else begin
         if (!prev_a && signal_a) dec_pos = signal_b ? dec_pos - 3'd1 : dec_pos + 3'd1;
         prev_a = signal_a;
      end
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_cmp++;
         if ({signal_a, signal_b} !== e.ab || position !== e.pos || done !== e.done ||
             cmd_ready !== e.ready || busy !== ~e.ready) begin
            n_err++;
            $display("FAIL cycle_check t=%0t: got ab=%b pos=%0d done=%b ready=%b busy=%b, want ab=%b pos=%0d done=%b ready=%b",
                     $time, {signal_a, signal_b}, position, done, cmd_ready, busy,
                     e.ab, e.pos, e.done, e.ready);
         end
      end
      if (done === 1'b1 && !rst) begin
         n_cmp++;
         if (dec_pos !== position) begin
            n_err++;
            $display("FAIL decoder_pos t=%0t: dut position=%0d, decoder model=%0d",
                     $time, position, dec_pos);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_steps = SW'(3);
      // reset held with cmd_valid high, then one idle cycle after release
      repeat (4) sbq.push_back(mk(2'b00, 3'd0, 1'b0, 1'b1));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cmd_valid = 1'b0;
      @(posedge clk); #1;

      run_cmd(1'b0, 1, 1'b0);            // CW 1 from 0
      do_reset();
      run_cmd(1'b1, 2, 1'b1);            // CCW 2 from 0, valid held while busy
      cmd_valid = 1'b0;
      do_reset();
      run_cmd(1'b0, 9, 1'b0);            // CW 9 from 0, wraps 7->0
      run_cmd(1'b0, 0, 1'b1);            // zero steps, valid held
      run_cmd(1'b0, 1, 1'b0);            // accepted the cycle cmd_ready rises
      run_cmd(1'b1, 15, 1'b0);           // maximum command, CCW
      do_reset();

      // reset during phase 1 of a CW 3-step command
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_steps = SW'(3);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      push_cmd(1'b0, 3, 3);
      sbq.push_back(mk(2'b00, 3'd0, 1'b0, 1'b1));
      exp_pos = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

`ifdef QUAD_ENCODER_GEN_ABORT_EN
      // abort during phase 1 of detent 2 of a 5-step CW command
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_steps = SW'(5);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      push_cmd(1'b0, 2, -1);
      repeat (10) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      repeat (6) @(posedge clk);
      #1;
`endif

      repeat (4) @(posedge clk);
      n_cmp++;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
